// File: rtl/native_to_wb_bridge_pkg.sv
// Shared definitions for the native-to-Wishbone bridge.
package native_to_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  SEL_ALL      = 4'hF;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // A read (no strobes) selects every byte lane.
    function automatic logic [3:0] strb_to_sel(input logic [3:0] strb);
        return (strb == 4'b0000) ? SEL_ALL : strb;
    endfunction

endpackage

// File: rtl/native_to_wb_bridge_wb_timeout_ctr.sv
// Bus watchdog counter: clear/enable counter that flags the last allowed cycle.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_BITS   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_BITS-1:0] LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_BITS-1:0] count;

    // Count cycles spent waiting; clear has priority over enable.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count <= '0;
        end else if (en_i) begin
            count <= count + 1'b1;
        end
    end

    // A zero cycle budget disables the watchdog entirely.
    assign expire_o = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/native_to_wb_bridge.sv
// Converts the CPU native valid/ready port into one Wishbone classic cycle,
// with a watchdog that aborts transfers to a silent slave.
module native_to_wb_bridge
    import native_to_wb_bridge_pkg::*;
#(
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_BITS   = 8,
    parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA = WB_DATA_WIDTH'(DEF_ERR_DATA)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mem_valid_i,
    input  logic [WB_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [3:0]               mem_wstrb_i,
    output logic                     mem_ready_o,
    output logic [WB_DATA_WIDTH-1:0] mem_rdata_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]               wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                     wb_ack_i,
    output logic                     bus_err_o,
    input  logic                     bus_err_clr_i
);

    state_t state, state_n;
    logic   latch_req;
    logic   take_ack;
    logic   take_timeout;
    logic   ctr_clr;
    logic   ctr_en;
    logic   expire;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_BITS   (TIMEOUT_BITS)
    ) u_timeout_ctr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (ctr_clr),
        .en_i     (ctr_en),
        .expire_o (expire)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath control; ack beats a coincident timeout.
    always_comb begin
        state_n      = state;
        latch_req    = 1'b0;
        take_ack     = 1'b0;
        take_timeout = 1'b0;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    latch_req = 1'b1;
                    ctr_clr   = 1'b1;
                    state_n   = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_ack_i) begin
                    take_ack = 1'b1;
                    state_n  = ST_RESP;
                end else if (expire) begin
                    take_timeout = 1'b1;
                    state_n      = ST_RESP;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Request capture on entry to BUS and response capture on exit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            if (latch_req) begin
                wb_adr_o <= mem_addr_i;
                wb_dat_o <= mem_wdata_i;
                wb_sel_o <= strb_to_sel(mem_wstrb_i);
                wb_we_o  <= |mem_wstrb_i;
            end
            if (take_ack || take_timeout) begin
                wb_we_o <= 1'b0;
            end
            if (take_ack) begin
                mem_rdata_o <= wb_dat_i;
            end else if (take_timeout) begin
                mem_rdata_o <= ERR_DATA;
            end
        end
    end

    // Sticky timeout flag; a new timeout overrides a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_err_o <= 1'b0;
        end else if (take_timeout) begin
            bus_err_o <= 1'b1;
        end else if (bus_err_clr_i) begin
            bus_err_o <= 1'b0;
        end
    end

    assign wb_cyc_o    = (state == ST_BUS);
    assign wb_stb_o    = wb_cyc_o;
    assign mem_ready_o = (state == ST_RESP);

endmodule

// File: tb/tb_native_to_wb_bridge.sv
// Scoreboard bench for native_to_wb_bridge with a short watchdog budget.
module tb_native_to_wb_bridge;

    localparam int TC = 4;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk;
    logic        rst_i;
    logic        mem_valid_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        bus_err_o;
    logic        bus_err_clr_i;

    native_to_wb_bridge #(
        .WB_DATA_WIDTH  (32),
        .WB_ADDR_WIDTH  (32),
        .TIMEOUT_CYCLES (TC),
        .TIMEOUT_BITS   (8),
        .ERR_DATA       (32'hDEADBEEF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mem_valid_i   (mem_valid_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_wstrb_i   (mem_wstrb_i),
        .mem_ready_o   (mem_ready_o),
        .mem_rdata_o   (mem_rdata_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .bus_err_o     (bus_err_o),
        .bus_err_clr_i (bus_err_clr_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic        we;
        logic        rd;
        logic        err;
        int          e_edge;
        int          ready_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;
    int   last_r = -10;
    bit   err_m = 1'b0;
    bit   cyc_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cnt == k.
    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cnt);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(mem_ready_o), 0);
        chk({tag, "_rdata"}, mem_rdata_o, 0);
        chk({tag, "_adr"},   wb_adr_o, 0);
        chk({tag, "_dat"},   wb_dat_o, 0);
        chk({tag, "_sel"},   32'(wb_sel_o), 0);
        chk({tag, "_we"},    32'(wb_we_o), 0);
        chk({tag, "_cyc"},   32'(wb_cyc_o), 0);
        chk({tag, "_stb"},   32'(wb_stb_o), 0);
        chk({tag, "_err"},   32'(bus_err_o), 0);
    endtask

    // Monitor: checks bus fields while cyc is high and pops on each ready pulse.
    always @(negedge clk) begin : monitor
        exp_t t;
        if (rst_i) begin
            cyc_seen = 1'b0;
        end else begin
            if (wb_cyc_o) begin
                if (exp_q.size() == 0) begin
                    chk("cyc_unexpected", 32'(wb_cyc_o), 0);
                end else begin
                    t = exp_q[0];
                    if (!cyc_seen) begin
                        chk("cyc_start_edge", cnt, t.e_edge);
                        cyc_seen = 1'b1;
                    end
                    chk("wb_adr", wb_adr_o, t.addr);
                    chk("wb_dat", wb_dat_o, t.wdata);
                    chk("wb_sel", 32'(wb_sel_o), 32'(t.sel));
                    chk("wb_we",  32'(wb_we_o), 32'(t.we));
                    chk("wb_stb", 32'(wb_stb_o), 1);
                end
            end
            if (mem_ready_o) begin
                chk("cyc_in_resp", 32'(wb_cyc_o), 0);
                chk("we_in_resp",  32'(wb_we_o), 0);
                if (exp_q.size() == 0) begin
                    chk("ready_unexpected", 32'(mem_ready_o), 0);
                end else begin
                    t = exp_q.pop_front();
                    chk("ready_edge", cnt, t.ready_cnt);
                    if (t.rd) chk("rdata", mem_rdata_o, t.rdata);
                    chk("bus_err", 32'(bus_err_o), 32'(t.err));
                end
                cyc_seen = 1'b0;
            end
        end
    end

    // One request; waits = wait states before ack, beyond the budget means a silent slave.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits,
                           input bit keep, input bit clr_hold);
        exp_t        t;
        logic [31:0] ack_dat;
        bit          acked;
        bit          done;
        int          e;
        acked   = (waits + 1 <= TC);
        ack_dat = $urandom;
        e       = (cnt + 1 > last_r + 2) ? cnt + 1 : last_r + 2;
        if (!acked) err_m = 1'b1;
        else if (clr_hold) err_m = 1'b0;
        t.addr      = addr;
        t.wdata     = wdata;
        t.sel       = (strb == 4'b0000) ? 4'hF : strb;
        t.we        = (strb != 4'b0000);
        t.rd        = (strb == 4'b0000);
        t.rdata     = acked ? ack_dat : ERRD;
        t.err       = err_m;
        t.e_edge    = e;
        t.ready_cnt = e + (acked ? waits + 1 : TC);
        exp_q.push_back(t);
        mem_valid_i   = 1'b1;
        mem_addr_i    = addr;
        mem_wdata_i   = wdata;
        mem_wstrb_i   = strb;
        bus_err_clr_i = clr_hold;
        wb_ack_i      = 1'b0;
        done          = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk); #1;
            if (mem_ready_o) begin
                done = 1'b1;
                break;
            end
            wb_ack_i = acked && (cnt == e + waits);
            wb_dat_i = wb_ack_i ? ack_dat : $urandom;
        end
        wb_ack_i      = 1'b0;
        bus_err_clr_i = 1'b0;
        if (!keep) mem_valid_i = 1'b0;
        if (!done) chk("ready_wait_bound", 32'(done), 1);
        last_r = cnt;
    endtask

    // Idle cycles with stray acks (ignored outside BUS) and optional clears.
    task automatic idle_gap(input int n, input bit allow_clr);
        for (int i = 0; i < n; i++) begin
            wb_ack_i      = $urandom_range(0, 1);
            wb_dat_i      = $urandom;
            bus_err_clr_i = allow_clr && ($urandom_range(0, 3) == 0);
            if (bus_err_clr_i) err_m = 1'b0;
            @(posedge clk); #1;
        end
        wb_ack_i      = 1'b0;
        bus_err_clr_i = 1'b0;
    endtask

    initial begin : stimulus
        logic [3:0] strb;
        int         waits;
        bit         keep;
        rst_i         = 1'b1;
        mem_valid_i   = 1'b0;
        mem_addr_i    = '0;
        mem_wdata_i   = '0;
        mem_wstrb_i   = '0;
        wb_dat_i      = '0;
        wb_ack_i      = 1'b0;
        bus_err_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_i = 1'b0;
        idle_gap(2, 1'b0);

        // Read from a zero-wait slave.
        run_txn(32'h0010_0004, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        idle_gap(1, 1'b0);
        // Byte write with three wait states.
        run_txn(32'h0020_0008, 32'h00AB_0000, 4'b0100, 3, 1'b0, 1'b0);
        idle_gap(1, 1'b0);
        // Silent slave: watchdog abort, then explicit clear.
        run_txn(32'h0030_0000, 32'h0, 4'b0000, 10, 1'b0, 1'b0);
        chk("err_after_timeout", 32'(bus_err_o), 1);
        bus_err_clr_i = 1'b1;
        @(posedge clk); #1;
        bus_err_clr_i = 1'b0;
        err_m = 1'b0;
        chk("err_after_clear", 32'(bus_err_o), 0);
        // Ack on the expiry edge.
        run_txn(32'h0040_0010, 32'h0, 4'b0000, TC - 1, 1'b0, 1'b0);
        // Clear held across a timeout: the set wins.
        run_txn(32'h0050_0000, 32'h1111_2222, 4'b1111, 9, 1'b0, 1'b1);
        // Clear held across a normal transfer clears the flag.
        run_txn(32'h0060_0000, 32'h0, 4'b0000, 1, 1'b0, 1'b1);
        // Back-to-back with valid held through RESP.
        run_txn(32'h0070_0000, 32'hCAFE_0001, 4'b0011, 0, 1'b1, 1'b0);
        run_txn(32'h0070_0004, 32'h0, 4'b0000, 2, 1'b1, 1'b0);
        run_txn(32'h0070_0008, 32'hCAFE_0003, 4'b1000, 0, 1'b0, 1'b0);
        idle_gap(1, 1'b0);

        // Reset mid-transfer, then a late ack that must be ignored.
        begin : reset_mid
            exp_t t;
            t.addr = 32'h0080_0000; t.wdata = 32'h5555_AAAA; t.sel = 4'hF;
            t.we = 1'b0; t.rd = 1'b1; t.rdata = '0; t.err = err_m;
            t.e_edge = cnt + 1; t.ready_cnt = -1;
            exp_q.push_back(t);
            mem_valid_i = 1'b1; mem_addr_i = t.addr; mem_wdata_i = t.wdata; mem_wstrb_i = 4'b0000;
            repeat (2) begin @(posedge clk); #1; end
            rst_i = 1'b1;
            mem_valid_i = 1'b0;
            @(posedge clk); #1;
            exp_q.delete();
            rst_i = 1'b0;
            err_m = 1'b0;
            check_zero_outputs("midreset");
            wb_ack_i = 1'b1;
            wb_dat_i = 32'h0BAD_0BAD;
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
            chk("late_ack_ready", 32'(mem_ready_o), 0);
            chk("late_ack_cyc", 32'(wb_cyc_o), 0);
            idle_gap(2, 1'b0);
        end
        run_txn(32'h0090_0000, 32'h0, 4'b0000, 1, 1'b0, 1'b0);
        idle_gap(1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            strb  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            waits = $urandom_range(0, 6);
            keep  = (i != 39) && ($urandom_range(0, 3) == 0);
            run_txn($urandom, $urandom, strb, waits, keep, $urandom_range(0, 7) == 0);
            if (!keep) idle_gap($urandom_range(0, 2), 1'b1);
        end

        idle_gap(3, 1'b0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
